h_cache_ring_buffer: RTL and testbench
======================================

# h_cache_ring_buffer

Multi-channel circular buffer for hot-cache line addresses. One tracker per memory channel pushes addresses, and the CSR unit / M5 manager pops them per channel. Each channel has a fill level, an almost-full flag, a selectable full-policy (stop or overwrite) and a saturating drop counter. It sits between the per-channel access trackers and the CSR block, replacing the single-channel, fixed-depth, index-reset buffer.

## Interface
- NUM_CHAN, 2, number of independent channels (≥1)
- DEPTH, 4096, entries per channel; power of two, ≥4
- ENTRY_WIDTH, 64, address width in bits
- IDX_W, $clog2(DEPTH), pointer width (derived)
- CHAN_W, max(1,$clog2(NUM_CHAN)), channel-select width (derived)
- AF_THRESH, DEPTH-16, almost-full level
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- wr_en  in  NUM_CHAN  per-channel push strobe from tracker
- wr_data  in  NUM_CHAN*ENTRY_WIDTH  push data; channel c at [c*ENTRY_WIDTH +: ENTRY_WIDTH]
- mode  in  NUM_CHAN  full-policy per channel: 0 = stop (drop new), 1 = overwrite oldest
- flush  in  NUM_CHAN  per-channel clear strobe from CSR
- rd_req  in  1  pop request
- rd_chan  in  CHAN_W  channel to pop; sampled with rd_req
- rd_resp  out  1  pulse, one cycle after every rd_req
- rd_valid  out  1  with rd_resp: 1 = data returned, 0 = channel was empty
- rd_data  out  ENTRY_WIDTH  popped entry, valid when rd_valid
- count_o  out  NUM_CHAN*(IDX_W+1)  fill level per channel, 0..DEPTH
- almost_full_o  out  NUM_CHAN  count ≥ AF_THRESH
- drop_cnt_o  out  NUM_CHAN*32  saturating count of discarded entries per channel

## Operation
- Per channel c: wr_ptr, rd_ptr (IDX_W bits, wrap modulo DEPTH), count (IDX_W+1 bits). Storage is one simple dual-port RAM per channel, DEPTH x ENTRY_WIDTH, with a registered read.
- Push on c with count<DEPTH: write mem[wr_ptr], then wr_ptr+1 and count+1.
- Push on c when full, mode=0: no write, drop_cnt+1.
- Push on c when full, mode=1, no pop on c: write mem[wr_ptr], then wr_ptr+1, rd_ptr+1, count unchanged, drop_cnt+1.
- Pop (rd_req, rd_chan=c, rd_chan<NUM_CHAN) with count>0: read mem[rd_ptr], then rd_ptr+1 and count−1.
- Pop on an empty channel, or with rd_chan≥NUM_CHAN: no state change; response has rd_valid=0.
- Simultaneous push and pop on c:
  - count>0: both accepted, count unchanged, no drop in either mode.
  - count=0: push accepted, pop rejected (rd_valid=0), count becomes 1.
  - Full and wr_ptr==rd_ptr: the RAM must be read-first, so the pop returns the old entry.
- Flush on c: wr_ptr, rd_ptr, count and drop_cnt go to 0. Flush wins over a push and a pop on c in the same cycle. The push is discarded and not counted as a drop. The pop gets rd_valid=0.
- A pop accepted in cycle N is unaffected by a flush in cycle N+1. Its rd_data is still delivered.
- drop_cnt saturates at 32'hFFFF_FFFF.
- Channels are fully independent except for the shared read port.

## Timing
- Reset (reset_n=0 at a clk edge):
  - All pointers, counts and drop counters go to 0.
  - rd_resp=0, rd_valid=0, rd_data=0, almost_full_o=0.
  - RAM contents are not cleared.
- Pushes are accepted every cycle with no backpressure.
- count_o and almost_full_o are registered and reflect a push/pop/flush in the cycle after it.
- Read latency is 1: rd_req in cycle N gives rd_resp=1 in N+1, with rd_valid/rd_data.
  - Back-to-back rd_req is allowed every cycle.
  - rd_data holds its last value while rd_resp=0.
- Occupancy is decided from count at the edge of cycle N, before that cycle's push. A push in N is not visible to a pop in N.
- Reset mid-operation: a pending rd_resp is cancelled. The cycle after reset has rd_resp=0.

## Test plan
- DEPTH=8, NUM_CHAN=2. Push 0x10..0x14 on ch0, then 5 pops on ch0 → rd_data 0x10..0x14 in order, each rd_valid=1; count_o[ch0] goes 5→0; ch1 stays at 0.
- Mode 0: push 10 entries 0xA0..0xA9 on ch1 → count=8, drop_cnt[ch1]=2; pops return 0xA0..0xA7, and a 9th pop returns rd_valid=0.
- Mode 1: push 10 entries 0xB0..0xB9 on ch0 → count=8, drop_cnt=2; pops return 0xB2..0xB9.
- Full ch0 in mode 1, push 0xC0 and pop ch0 in the same cycle → rd_data is the oldest entry, count stays 8, drop_cnt unchanged. The next 7 pops drain the remaining entries, then 0xC0 comes out last.
- Empty ch1, push 0xD0 and pop ch1 in the same cycle → rd_valid=0, count=1; a pop next cycle returns 0xD0.
- ch0 holding 5 entries, drop_cnt=3: assert flush together with a push → count=0, drop_cnt=0, and the next pop returns rd_valid=0. Then reset_n=0 with a pop in flight → rd_resp=0 the following cycle and all outputs at their reset values.

Source files
------------

// File: rtl/h_cache_ring_buffer_if.sv
// Push/pop/status bundle between the per-channel trackers, the CSR block and h_cache_ring_buffer.
// The master side drives pushes, flushes and pop requests; the slave side returns data and status.
interface h_cache_ring_buffer_if #(
    parameter int unsigned NUM_CHAN    = 2,
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned ENTRY_WIDTH = 64
);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned CHAN_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int unsigned DROP_W = 32;

    logic [NUM_CHAN-1:0]             wr_en;
    logic [NUM_CHAN*ENTRY_WIDTH-1:0] wr_data;
    logic [NUM_CHAN-1:0]             mode;
    logic [NUM_CHAN-1:0]             flush;
    logic                            rd_req;
    logic [CHAN_W-1:0]               rd_chan;
    logic                            rd_resp;
    logic                            rd_valid;
    logic [ENTRY_WIDTH-1:0]          rd_data;
    logic [NUM_CHAN*CNT_W-1:0]       count_o;
    logic [NUM_CHAN-1:0]             almost_full_o;
    logic [NUM_CHAN*DROP_W-1:0]      drop_cnt_o;

    modport master (
        output wr_en, wr_data, mode, flush, rd_req, rd_chan,
        input  rd_resp, rd_valid, rd_data, count_o, almost_full_o, drop_cnt_o
    );

    modport slave (
        input  wr_en, wr_data, mode, flush, rd_req, rd_chan,
        output rd_resp, rd_valid, rd_data, count_o, almost_full_o, drop_cnt_o
    );
endinterface

// File: rtl/h_cache_ring_buffer.sv
// Multi-channel circular buffer of hot-cache line addresses with a shared pop port.
// Each channel has its own RAM, pointers, fill level, almost-full flag, full policy and drop counter.
module h_cache_ring_buffer #(
    parameter int unsigned NUM_CHAN    = 2,
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned ENTRY_WIDTH = 64,
    parameter int unsigned AF_THRESH   = DEPTH - 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    h_cache_ring_buffer_if.slave    bus
);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned DROP_W = 32;

    logic [NUM_CHAN-1:0][IDX_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [NUM_CHAN-1:0][IDX_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [NUM_CHAN-1:0][CNT_W-1:0]       count_q, count_d;
    logic [NUM_CHAN-1:0][DROP_W-1:0]      drop_q, drop_d;
    logic [NUM_CHAN-1:0]                  af_q, af_d;
    logic                                 rd_resp_q, rd_resp_d;
    logic                                 rd_valid_q, rd_valid_d;
    logic [ENTRY_WIDTH-1:0]               rd_data_q, rd_data_d;

    logic [NUM_CHAN-1:0]                  mem_we;
    logic [NUM_CHAN-1:0][ENTRY_WIDTH-1:0] wdata;
    logic [NUM_CHAN-1:0][ENTRY_WIDTH-1:0] ram_rdata;

    assign wdata = bus.wr_data;

    // One simple dual-port RAM per channel; the read side is captured into rd_data_q,
    // and the non-blocking write keeps it read-first when both ports hit the same entry.
    for (genvar g = 0; g < int'(NUM_CHAN); g++) begin : g_chan
        logic [ENTRY_WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (mem_we[g]) begin
                mem[wr_ptr_q[g]] <= wdata[g];
            end
        end

        assign ram_rdata[g] = mem[rd_ptr_q[g]];
    end

    // Per-channel next state; occupancy is judged on count_q, before this cycle's push.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_d     = drop_q;
        af_d       = '0;
        mem_we     = '0;
        rd_resp_d  = bus.rd_req;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;

        for (int unsigned c = 0; c < NUM_CHAN; c++) begin
            if (bus.flush[c]) begin
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
                count_d[c]  = '0;
                drop_d[c]   = '0;
            end else begin
                if (bus.rd_req && (32'(bus.rd_chan) == c) && (count_q[c] != '0)) begin
                    rd_valid_d  = 1'b1;
                    rd_data_d   = ram_rdata[c];
                    rd_ptr_d[c] = rd_ptr_q[c] + IDX_W'(1);
                    count_d[c]  = count_q[c] - CNT_W'(1);
                end

                if (bus.wr_en[c]) begin
                    if (count_d[c] != CNT_W'(DEPTH)) begin
                        // Room after any same-cycle pop: plain append.
                        mem_we[c]   = 1'b1;
                        wr_ptr_d[c] = wr_ptr_q[c] + IDX_W'(1);
                        count_d[c]  = count_d[c] + CNT_W'(1);
                    end else begin
                        if (bus.mode[c]) begin
                            mem_we[c]   = 1'b1;
                            wr_ptr_d[c] = wr_ptr_q[c] + IDX_W'(1);
                            rd_ptr_d[c] = rd_ptr_q[c] + IDX_W'(1);
                        end
                        if (drop_q[c] != '1) begin
                            drop_d[c] = drop_q[c] + DROP_W'(1);
                        end
                    end
                end
            end

            af_d[c] = (32'(count_d[c]) >= AF_THRESH);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            af_q       <= '0;
            rd_resp_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            af_q       <= af_d;
            rd_resp_q  <= rd_resp_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.rd_resp       = rd_resp_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.count_o       = count_q;
    assign bus.almost_full_o = af_q;
    assign bus.drop_cnt_o    = drop_q;
endmodule

// File: tb/tb_h_cache_ring_buffer.sv
// Bench for h_cache_ring_buffer: directed vector table, hand-written reset/flush sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_h_cache_ring_buffer;
    localparam int unsigned NUM_CHAN = 2;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned EW       = 64;
    localparam int unsigned AF       = 6;
    localparam int unsigned CNT_W    = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    h_cache_ring_buffer_if #(.NUM_CHAN(NUM_CHAN), .DEPTH(DEPTH), .ENTRY_WIDTH(EW)) bus ();

    h_cache_ring_buffer #(
        .NUM_CHAN(NUM_CHAN), .DEPTH(DEPTH), .ENTRY_WIDTH(EW), .AF_THRESH(AF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    // Reference model: one FIFO queue per channel plus drop counters.
    logic [EW-1:0]   mq [NUM_CHAN][$];
    longint unsigned mdrop [NUM_CHAN];
    logic            m_resp, m_valid;
    logic [EW-1:0]   m_data;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  we;
        logic [63:0] d0, d1;
        logic [1:0]  md, fl;
        logic        rq, rc;
        logic        ev;
        logic [63:0] ed;
        int          c0, c1, dr0, dr1;
    } vec_t;
    vec_t vecs[$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void add(input logic [1:0] we, input logic [63:0] d0, input logic [63:0] d1,
                                input logic [1:0] md, input logic [1:0] fl, input logic rq,
                                input logic rc, input logic ev, input logic [63:0] ed,
                                input int c0, input int c1, input int dr0, input int dr1);
        vec_t v;
        v.we = we; v.d0 = d0; v.d1 = d1; v.md = md; v.fl = fl; v.rq = rq; v.rc = rc;
        v.ev = ev; v.ed = ed; v.c0 = c0; v.c1 = c1; v.dr0 = dr0; v.dr1 = dr1;
        vecs.push_back(v);
    endfunction

    function automatic void model_update(input bit rst, input logic [1:0] we, input logic [63:0] d0,
                                         input logic [63:0] d1, input logic [1:0] md,
                                         input logic [1:0] fl, input logic rq, input logic rc);
        if (rst) begin
            for (int c = 0; c < int'(NUM_CHAN); c++) begin
                mq[c].delete();
                mdrop[c] = 0;
            end
            m_resp = 1'b0; m_valid = 1'b0; m_data = '0;
            return;
        end
        m_resp  = rq;
        m_valid = 1'b0;
        if (rq && (32'(rc) < NUM_CHAN) && !fl[rc] && (mq[rc].size() > 0)) begin
            m_valid = 1'b1;
            m_data  = mq[rc].pop_front();
        end
        for (int c = 0; c < int'(NUM_CHAN); c++) begin
            if (fl[c]) begin
                mq[c].delete();
                mdrop[c] = 0;
            end else if (we[c]) begin
                if (mq[c].size() < int'(DEPTH)) begin
                    mq[c].push_back(c == 0 ? d0 : d1);
                end else begin
                    if (md[c]) begin
                        void'(mq[c].pop_front());
                        mq[c].push_back(c == 0 ? d0 : d1);
                    end
                    if (mdrop[c] < 64'hFFFF_FFFF) mdrop[c]++;
                end
            end
        end
    endfunction

    task automatic compare_model();
        check("rd_resp", 64'(bus.rd_resp), 64'(m_resp));
        check("rd_valid", 64'(bus.rd_valid), 64'(m_valid));
        check("rd_data", bus.rd_data, m_data);
        for (int c = 0; c < int'(NUM_CHAN); c++) begin
            check($sformatf("count%0d", c), 64'(bus.count_o[c*CNT_W +: CNT_W]), 64'(mq[c].size()));
            check($sformatf("af%0d", c), 64'(bus.almost_full_o[c]), 64'(mq[c].size() >= int'(AF)));
            check($sformatf("drop%0d", c), 64'(bus.drop_cnt_o[c*32 +: 32]), mdrop[c]);
        end
    endtask

    task automatic step(input bit rst, input logic [1:0] we, input logic [63:0] d0,
                        input logic [63:0] d1, input logic [1:0] md, input logic [1:0] fl,
                        input logic rq, input logic rc);
        bus.wr_en   = we;
        bus.wr_data = {d1, d0};
        bus.mode    = md;
        bus.flush   = fl;
        bus.rd_req  = rq;
        bus.rd_chan = rc;
        reset_n     = !rst;
        model_update(rst, we, d0, d1, md, fl, rq, rc);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    initial begin
        // Directed table: expected values worked out by hand from the buffer rules.
        for (int i = 0; i < 5; i++) add(2'b01, 64'h10 + 64'(i), 0, 2'b00, 2'b00, 0, 0, 0, 0, i + 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(2'b00, 0, 0, 2'b00, 2'b00, 1, 0, 1, 64'h10 + 64'(i), 4 - i, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            add(2'b10, 0, 64'hA0 + 64'(i), 2'b00, 2'b00, 0, 0, 0, 0, 0, (i < 8) ? i + 1 : 8, 0, (i >= 8) ? i - 7 : 0);
        for (int i = 0; i < 8; i++) add(2'b00, 0, 0, 2'b00, 2'b00, 1, 1, 1, 64'hA0 + 64'(i), 0, 7 - i, 0, 2);
        add(2'b00, 0, 0, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0, 2);
        for (int i = 0; i < 10; i++)
            add(2'b01, 64'hB0 + 64'(i), 0, 2'b01, 2'b00, 0, 0, 0, 0, (i < 8) ? i + 1 : 8, 0, (i >= 8) ? i - 7 : 0, 2);
        for (int i = 0; i < 8; i++) add(2'b00, 0, 0, 2'b01, 2'b00, 1, 0, 1, 64'hB2 + 64'(i), 7 - i, 0, 2, 2);
        for (int i = 0; i < 8; i++) add(2'b01, 64'hE0 + 64'(i), 0, 2'b01, 2'b00, 0, 0, 0, 0, i + 1, 0, 2, 2);
        add(2'b01, 64'hC0, 0, 2'b01, 2'b00, 1, 0, 1, 64'hE0, 8, 0, 2, 2);
        for (int i = 0; i < 7; i++) add(2'b00, 0, 0, 2'b01, 2'b00, 1, 0, 1, 64'hE1 + 64'(i), 7 - i, 0, 2, 2);
        add(2'b00, 0, 0, 2'b01, 2'b00, 1, 0, 1, 64'hC0, 0, 0, 2, 2);
        add(2'b10, 0, 64'hD0, 2'b01, 2'b00, 1, 1, 0, 0, 0, 1, 2, 2);
        add(2'b00, 0, 0, 2'b01, 2'b00, 1, 1, 1, 64'hD0, 0, 0, 2, 2);
        for (int i = 0; i < 8; i++) add(2'b01, 64'hF0 + 64'(i), 0, 2'b01, 2'b00, 0, 0, 0, 0, i + 1, 0, 2, 2);
        add(2'b01, 64'hF8, 0, 2'b01, 2'b00, 0, 0, 0, 0, 8, 0, 3, 2);
        for (int i = 0; i < 3; i++) add(2'b00, 0, 0, 2'b01, 2'b00, 1, 0, 1, 64'hF1 + 64'(i), 7 - i, 0, 3, 2);
        add(2'b01, 64'h99, 0, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2);
        add(2'b00, 0, 0, 2'b01, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2);
        add(2'b10, 0, 64'h66, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 2);
        add(2'b00, 0, 0, 2'b00, 2'b10, 1, 1, 0, 0, 0, 0, 0, 0);

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("reset_resp", 64'(bus.rd_resp), 0);
        check("reset_data", bus.rd_data, 0);

        foreach (vecs[i]) begin
            step(0, vecs[i].we, vecs[i].d0, vecs[i].d1, vecs[i].md, vecs[i].fl, vecs[i].rq, vecs[i].rc);
            check($sformatf("vec%0d_resp", i), 64'(bus.rd_resp), 64'(vecs[i].rq));
            check($sformatf("vec%0d_valid", i), 64'(bus.rd_valid), 64'(vecs[i].ev));
            if (vecs[i].ev) check($sformatf("vec%0d_data", i), bus.rd_data, vecs[i].ed);
            check($sformatf("vec%0d_cnt0", i), 64'(bus.count_o[0 +: CNT_W]), 64'(vecs[i].c0));
            check($sformatf("vec%0d_cnt1", i), 64'(bus.count_o[CNT_W +: CNT_W]), 64'(vecs[i].c1));
            check($sformatf("vec%0d_drop0", i), 64'(bus.drop_cnt_o[0 +: 32]), 64'(vecs[i].dr0));
            check($sformatf("vec%0d_drop1", i), 64'(bus.drop_cnt_o[32 +: 32]), 64'(vecs[i].dr1));
        end

        // Randomized traffic: alternate write-heavy and read-heavy phases to reach full and empty.
        begin
            logic [1:0] md;
            md = 2'b00;
            for (int i = 0; i < 1200; i++) begin
                logic [1:0] we, fl;
                logic rq, rc;
                int wp;
                if (i % 60 == 0) md = 2'($urandom_range(0, 3));
                wp = ((i / 100) % 2 == 0) ? 80 : 25;
                we[0] = ($urandom_range(0, 99) < wp);
                we[1] = ($urandom_range(0, 99) < wp);
                fl[0] = ($urandom_range(0, 47) == 0);
                fl[1] = ($urandom_range(0, 47) == 0);
                rq    = ($urandom_range(0, 99) < 55);
                rc    = 1'($urandom_range(0, 1));
                step(0, we, {$urandom, $urandom}, {$urandom, $urandom}, md, fl, rq, rc);
            end
        end

        // Reset with a pop in flight: response is cancelled and rd_data returns to zero.
        step(0, 2'b00, 0, 0, 2'b00, 2'b11, 0, 0);
        step(0, 2'b01, 64'h77, 0, 2'b00, 2'b00, 0, 0);
        step(0, 2'b01, 64'h78, 0, 2'b00, 2'b00, 1, 0);
        check("pre_rst_data", bus.rd_data, 64'h77);
        step(1, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0);
        check("rst_resp", 64'(bus.rd_resp), 0);
        check("rst_valid", 64'(bus.rd_valid), 0);
        check("rst_data", bus.rd_data, 0);
        check("rst_count", 64'(bus.count_o), 0);
        check("rst_af", 64'(bus.almost_full_o), 0);
        check("rst_drop", 64'(bus.drop_cnt_o), 0);
        step(0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0);
        check("post_rst_valid", 64'(bus.rd_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
